// File: rtl/window_gen.sv
`default_nettype none
// ============================================================================
// window_gen : trigger-started delay/width window generator with done/missed
// Rev 1.0
// ============================================================================
module window_gen #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trig,
  input  logic [CNT_WIDTH-1:0] delay,
  input  logic [CNT_WIDTH-1:0] width,
  output logic                 out,
  output logic                 busy,
  output logic                 done,
  output logic                 missed
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DELAY  = 2'd1,
    S_ACTIVE = 2'd2,
    S_END    = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] C_ZERO = '0;

  state_t               state, state_n;
  logic                 trig_q;
  logic                 rise;
  logic                 missed_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0] wid_r, wid_n;

  assign rise = trig & ~trig_q;

  // The counter is loaded with the phase length and stops at 1, so it never wraps.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    wid_n    = wid_r;
    missed_n = 1'b0;
    case (state)
      S_IDLE, S_END: begin
        state_n = S_IDLE;
        if (rise) begin
          wid_n = width;
          if (delay != C_ZERO) begin
            state_n = S_DELAY;
            cnt_n   = delay;
          end else if (width != C_ZERO) begin
            state_n = S_ACTIVE;
            cnt_n   = width;
          end else begin
            state_n = S_END;
          end
        end
      end
      S_DELAY: begin
        missed_n = rise;
        if (cnt == C_ONE) begin
          if (wid_r != C_ZERO) begin
            state_n = S_ACTIVE;
            cnt_n   = wid_r;
          end else begin
            state_n = S_END;
          end
        end else begin
          cnt_n = cnt - C_ONE;
        end
      end
      S_ACTIVE: begin
        missed_n = rise;
        if (cnt == C_ONE) begin
          state_n = S_END;
        end else begin
          cnt_n = cnt - C_ONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // trig_q resets high so a trigger held across reset needs a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      trig_q <= 1'b1;
      cnt    <= C_ZERO;
      wid_r  <= C_ZERO;
      out    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      missed <= 1'b0;
    end else begin
      state  <= state_n;
      trig_q <= trig;
      cnt    <= cnt_n;
      wid_r  <= wid_n;
      out    <= (state_n == S_ACTIVE);
      busy   <= (state_n == S_DELAY) || (state_n == S_ACTIVE);
      done   <= (state_n == S_END);
      missed <= missed_n;
    end
  end

endmodule
`default_nettype wire
